qspi_distributor: RTL and testbench
===================================

Name: qspi_distributor

Overview:
- Inbound counterpart of the collector: receives 4-bit QSPI nibbles from the host link and assembles them into full encrypter-width packets.
- Dispatches each packet to the encrypter array in strict round-robin order using a per-encrypter load/ready handshake.
- Sits between the QSPI receive front end and the encrypter inputs.
- Has a one-packet holding buffer, so the next packet can be assembled while the current one waits for its encrypter.

Parameters:
- DATA_WIDTH, 64, packet width in bits; must be a multiple of 4.
- NUM_ENCRYPTERS, 4, number of encrypter instances; must be ≥2.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- qspi_data  in  4  nibble from QSPI receiver.
- qspi_valid  in  1  qspi_data valid this cycle.
- qspi_start  in  1  qualifies nibble as first of a packet; meaningful only with qspi_valid.
- qspi_ready  out  1  distributor can accept a nibble.
- encrypters_data  out  DATA_WIDTH  packet broadcast to all encrypters.
- encrypters_load  out  NUM_ENCRYPTERS  one-hot load request; bit i targets encrypter i.
- encrypters_ready  in  NUM_ENCRYPTERS  encrypter i can take a packet.
- dispatch_idx  out  clog2(NUM_ENCRYPTERS)  index of the next encrypter to be served.
- frame_error  out  1  sticky framing-error flag.

Behaviour:
- Reset values (asynchronous, take effect immediately):
  - nibble_count=0, hold_full=0, dispatch_idx=0.
  - encrypters_data=0, encrypters_load=0, frame_error=0.
  - qspi_ready=1.
- A reset mid-packet or mid-dispatch drops all in-flight data.
- Nibble accept: qspi_valid && qspi_ready at posedge.
  - Nibble k is stored in bits [4k+3:4k]; the first nibble is the LSBs. NIBBLES = DATA_WIDTH/4.
- Framing rules:
  - Accepted nibble with qspi_start=1 and nibble_count=0: store as nibble 0, count becomes 1.
  - Accepted nibble with qspi_start=1 and nibble_count≠0: discard the partial packet, set frame_error, store the nibble as nibble 0, count becomes 1.
  - Accepted nibble with qspi_start=0 and nibble_count=0: discard the nibble and set frame_error.
  - Cycles with qspi_valid=0 leave all state unchanged.
- Packet completion: on the accepted nibble with nibble_count=NIBBLES-1:
  - the assembled word, including this nibble, is copied to the hold register;
  - hold_full=1, nibble_count=0.
- qspi_ready = !(hold_full && nibble_count==NIBBLES-1). It is combinational from registered state only.
  - The distributor stalls only on the final nibble while the hold register is occupied.
  - A hold register freed in the same cycle does not raise ready until the next cycle.
- Dispatch:
  - While hold_full=1, encrypters_data = hold register and encrypters_load = one-hot(dispatch_idx).
  - encrypters_load and encrypters_data are registered and stay stable until the transfer.
- Transfer: encrypters_load[i] && encrypters_ready[i] at posedge. Then:
  - hold_full=0 and encrypters_load=0 in the next cycle;
  - dispatch_idx increments, wrapping NUM_ENCRYPTERS-1 → 0.
- Ordering rules:
  - Strict round-robin: busy encrypters are never skipped.
  - Ready bits of non-targeted encrypters are ignored.
- Latency:
  - Final nibble accepted at edge N → encrypters_load visible after edge N.
  - Earliest transfer at edge N+1.
- Simultaneous transfer and final-nibble acceptance cannot occur, because ready is low in that case.
- encrypters_data retains its last value when idle; no zeroing after transfer.
- frame_error is cleared only by reset.

Decomposition:
- Shared package/constants file contains:
  - DATA_WIDTH, NUM_ENCRYPTERS;
  - NIBBLES = DATA_WIDTH/4;
  - NIBBLE_CNT_W = clog2(NIBBLES);
  - IDX_W = clog2(NUM_ENCRYPTERS).
- Sub-module qspi_nibble_assembler: nibble counter, framing checks, assembly register, completion pulse, frame_error.
- The top level holds the hold register, the round-robin dispatcher and qspi_ready.

Test Plan:
1. Basic assembly: after reset, send nibbles 0x0..0xF (qspi_start on the first) with 3 random valid gaps, encrypters_ready=4'b1111 → encrypters_data=64'hFEDCBA9876543210, load=4'b0001 for 1 cycle, dispatch_idx=1, frame_error=0.
2. Back-pressure: encrypters_ready=0, send packets A and B back to back.
   - qspi_ready drops at B's 16th nibble.
   - Raise ready[0] → A loads on 4'b0001, B is then accepted and loads on 4'b0010.
3. Wrap: 5 packets, all ready → load sequence 0001, 0010, 0100, 1000, 0001; dispatch_idx 1, 2, 3, 0, 1.
4. Mid-packet restart: 7 nibbles, then qspi_start with 16 nibbles 0xA → frame_error=1, one packet 64'hAAAAAAAAAAAAAAAA dispatched, no partial dispatch.
5. Orphan nibble: qspi_valid with qspi_start=0 while idle → frame_error=1, no load; a following framed packet is dispatched normally.
6. Reset mid-dispatch: load=4'b0100 held (ready[2]=0), assert reset between edges → load=0, dispatch_idx=0, qspi_ready=1, frame_error=0 immediately.

Source files
------------

// File: rtl/qspi_distributor_pkg.sv
// Shared sizing constants and helpers for the QSPI inbound distributor.
package qspi_distributor_pkg;

  localparam int DATA_WIDTH     = 64;
  localparam int NUM_ENCRYPTERS = 4;
  localparam int NIBBLES        = DATA_WIDTH / 4;
  localparam int NIBBLE_CNT_W   = $clog2(NIBBLES);
  localparam int IDX_W          = $clog2(NUM_ENCRYPTERS);

  function automatic logic [NUM_ENCRYPTERS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    idx_onehot      = '0;
    idx_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/qspi_distributor_if.sv
// QSPI receive link plus encrypter load/ready bus; the distributor is the slave side.
interface qspi_distributor_if;
  import qspi_distributor_pkg::*;

  logic [3:0]                qspi_data;
  logic                      qspi_valid;
  logic                      qspi_start;
  logic                      qspi_ready;
  logic [DATA_WIDTH-1:0]     encrypters_data;
  logic [NUM_ENCRYPTERS-1:0] encrypters_load;
  logic [NUM_ENCRYPTERS-1:0] encrypters_ready;

  modport master (
    output qspi_data, qspi_valid, qspi_start, encrypters_ready,
    input  qspi_ready, encrypters_data, encrypters_load
  );

  modport slave (
    input  qspi_data, qspi_valid, qspi_start, encrypters_ready,
    output qspi_ready, encrypters_data, encrypters_load
  );
endinterface

// File: rtl/qspi_nibble_assembler.sv
// Counts accepted nibbles, enforces start framing and builds the packet LSB-first.
module qspi_nibble_assembler
  import qspi_distributor_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    accept_i,
  input  logic                    start_i,
  input  logic [3:0]              nibble_i,
  output logic [NIBBLE_CNT_W-1:0] count_o,
  output logic [DATA_WIDTH-1:0]   word_o,
  output logic                    done_o,
  output logic                    frame_error_o
);

  logic [NIBBLE_CNT_W-1:0] count_q;
  logic [DATA_WIDTH-1:0]   asm_q;
  logic                    frame_error_q;
  logic                    last_nibble;

  assign last_nibble = (count_q == NIBBLE_CNT_W'(NIBBLES - 1));

  // NOTE: state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q       <= '0;
      // NOTE: the assembly register is reset only so encrypters_data-style observers see zeros; it is not needed for correctness.
      asm_q         <= '0;
      frame_error_q <= 1'b0;
    end else if (accept_i) begin
      if (start_i) begin
        if (count_q != '0) frame_error_q <= 1'b1;
        asm_q[3:0] <= nibble_i;
        count_q    <= NIBBLE_CNT_W'(1);
      end else if (count_q == '0) begin
        frame_error_q <= 1'b1;
      end else begin
        asm_q[4*count_q +: 4] <= nibble_i;
        count_q <= last_nibble ? '0 : count_q + NIBBLE_CNT_W'(1);
      end
    end
  end

  // Completed word must include the nibble arriving on this very edge.
  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    word_o                  = asm_q;
    word_o[4*count_q +: 4]  = nibble_i;
  end

  assign done_o        = accept_i && !start_i && last_nibble;
  assign count_o       = count_q;
  assign frame_error_o = frame_error_q;

endmodule

// File: rtl/qspi_distributor.sv
// Assembles QSPI nibbles into packets and hands them to encrypters in strict round-robin.
module qspi_distributor
  import qspi_distributor_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  qspi_distributor_if.slave    bus,
  output logic [IDX_W-1:0]     dispatch_idx_o,
  output logic                 frame_error_o
);

  logic [NIBBLE_CNT_W-1:0]   count;
  logic [DATA_WIDTH-1:0]     word;
  logic                      done;
  logic                      accept;
  logic                      ready;
  logic                      transfer;

  logic [DATA_WIDTH-1:0]     data_q;
  logic [NUM_ENCRYPTERS-1:0] load_q;
  logic                      hold_full_q;
  logic [IDX_W-1:0]          idx_q;

  // Stall only when the final nibble would need a hold register that is still occupied.
  assign ready    = !(hold_full_q && (count == NIBBLE_CNT_W'(NIBBLES - 1)));
  assign accept   = bus.qspi_valid && ready;
  assign transfer = |(load_q & bus.encrypters_ready);

  qspi_nibble_assembler u_assembler (
    .clk           (clk),
    .reset         (reset),
    .accept_i      (accept),
    .start_i       (bus.qspi_start),
    .nibble_i      (bus.qspi_data),
    .count_o       (count),
    .word_o        (word),
    .done_o        (done),
    .frame_error_o (frame_error_o)
  );

  // Completion and transfer are mutually exclusive because ready is low in that case.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q      <= '0;
      load_q      <= '0;
      hold_full_q <= 1'b0;
      idx_q       <= '0;
    end else if (done) begin
      data_q      <= word;
      load_q      <= idx_onehot(idx_q);
      hold_full_q <= 1'b1;
    end else if (transfer) begin
      load_q      <= '0;
      hold_full_q <= 1'b0;
      idx_q       <= (idx_q == IDX_W'(NUM_ENCRYPTERS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  assign bus.qspi_ready      = ready;
  assign bus.encrypters_data = data_q;
  assign bus.encrypters_load = load_q;
  assign dispatch_idx_o      = idx_q;

endmodule

// File: tb/tb_qspi_distributor.sv
// Directed bench for qspi_distributor: framing, back-pressure, round-robin wrap and async reset.
module tb_qspi_distributor;
  import qspi_distributor_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [IDX_W-1:0] dispatch_idx;
  logic             frame_error;
  int               checks   = 0;
  int               failures = 0;

  qspi_distributor_if bus ();

  qspi_distributor dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .dispatch_idx_o (dispatch_idx),
    .frame_error_o  (frame_error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.qspi_valid = 1'b0;
    bus.qspi_start = 1'b0;
    bus.qspi_data  = 4'h0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_nibble(input logic [3:0] n, input logic s);
    int waited = 0;
    while (!bus.qspi_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (waited >= 100) check("ready_timeout", 64'(bus.qspi_ready), 64'd1);
    bus.qspi_data  = n;
    bus.qspi_start = s;
    bus.qspi_valid = 1'b1;
    tick();
    bus.qspi_valid = 1'b0;
    bus.qspi_start = 1'b0;
  endtask

  task automatic send_pkt(input logic [63:0] w, input logic [15:0] gap_mask);
    for (int k = 0; k < 16; k++) begin
      send_nibble(w[4*k +: 4], k == 0);
      if (gap_mask[k]) tick();
    end
  endtask

  initial begin
    logic [63:0] pkt_a;
    logic [63:0] pkt_b;
    logic [63:0] pkt;

    bus.encrypters_ready = '0;
    apply_reset();

    // Reset state
    check("rst_ready", 64'(bus.qspi_ready), 64'd1);
    check("rst_load",  64'(bus.encrypters_load), 64'd0);
    check("rst_data",  bus.encrypters_data, 64'd0);
    check("rst_idx",   64'(dispatch_idx), 64'd0);
    check("rst_ferr",  64'(frame_error), 64'd0);

    // 1. Basic assembly with idle gaps
    bus.encrypters_ready = 4'b1111;
    send_pkt(64'hFEDCBA9876543210, 16'b0000_1000_1000_1000);
    check("t1_load", 64'(bus.encrypters_load), 64'h1);
    check("t1_data", bus.encrypters_data, 64'hFEDCBA9876543210);
    check("t1_idx_before", 64'(dispatch_idx), 64'd0);
    tick();
    check("t1_load_clear", 64'(bus.encrypters_load), 64'h0);
    check("t1_idx", 64'(dispatch_idx), 64'd1);
    check("t1_ferr", 64'(frame_error), 64'd0);
    check("t1_data_retained", bus.encrypters_data, 64'hFEDCBA9876543210);

    // 2. Back-pressure
    apply_reset();
    bus.encrypters_ready = 4'b0000;
    pkt_a = 64'h1122334455667788;
    pkt_b = 64'h99AABBCCDDEEFF00;
    send_pkt(pkt_a, 16'h0000);
    check("t2_a_load", 64'(bus.encrypters_load), 64'h1);
    check("t2_a_data", bus.encrypters_data, pkt_a);
    for (int k = 0; k < 15; k++) send_nibble(pkt_b[4*k +: 4], k == 0);
    check("t2_stall", 64'(bus.qspi_ready), 64'd0);
    bus.qspi_data  = pkt_b[63:60];
    bus.qspi_valid = 1'b1;
    bus.encrypters_ready = 4'b1110;
    tick();
    check("t2_ignore_other_ready", 64'(bus.encrypters_load), 64'h1);
    check("t2_still_stalled", 64'(bus.qspi_ready), 64'd0);
    check("t2_a_stable", bus.encrypters_data, pkt_a);
    bus.encrypters_ready = 4'b0001;
    tick();
    check("t2_a_transferred", 64'(bus.encrypters_load), 64'h0);
    check("t2_idx1", 64'(dispatch_idx), 64'd1);
    check("t2_ready_back", 64'(bus.qspi_ready), 64'd1);
    bus.encrypters_ready = 4'b0000;
    tick();
    bus.qspi_valid = 1'b0;
    check("t2_b_load", 64'(bus.encrypters_load), 64'h2);
    check("t2_b_data", bus.encrypters_data, pkt_b);
    bus.encrypters_ready = 4'b0010;
    tick();
    check("t2_b_transferred", 64'(bus.encrypters_load), 64'h0);
    check("t2_idx2", 64'(dispatch_idx), 64'd2);

    // 3. Round-robin wrap
    apply_reset();
    bus.encrypters_ready = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      pkt = 64'h0123456789ABCDEF ^ 64'(i);
      send_pkt(pkt, 16'h0000);
      check("t3_load", 64'(bus.encrypters_load), 64'(4'b0001 << (i % 4)));
      check("t3_data", bus.encrypters_data, pkt);
      tick();
      check("t3_idx", 64'(dispatch_idx), 64'((i + 1) % 4));
    end

    // 4. Mid-packet restart
    apply_reset();
    bus.encrypters_ready = 4'b1111;
    for (int k = 0; k < 7; k++) send_nibble(4'h5, k == 0);
    check("t4_no_partial", 64'(bus.encrypters_load), 64'h0);
    check("t4_ferr_clean", 64'(frame_error), 64'd0);
    send_nibble(4'hA, 1'b1);
    check("t4_ferr", 64'(frame_error), 64'd1);
    check("t4_no_partial2", 64'(bus.encrypters_load), 64'h0);
    for (int k = 1; k < 16; k++) send_nibble(4'hA, 1'b0);
    check("t4_load", 64'(bus.encrypters_load), 64'h1);
    check("t4_data", bus.encrypters_data, 64'hAAAAAAAAAAAAAAAA);
    tick();
    check("t4_idx", 64'(dispatch_idx), 64'd1);

    // 5. Orphan nibble
    apply_reset();
    bus.encrypters_ready = 4'b1111;
    send_nibble(4'h7, 1'b0);
    check("t5_ferr", 64'(frame_error), 64'd1);
    check("t5_no_load", 64'(bus.encrypters_load), 64'h0);
    check("t5_ready", 64'(bus.qspi_ready), 64'd1);
    send_pkt(64'h0F1E2D3C4B5A6978, 16'h0000);
    check("t5_load", 64'(bus.encrypters_load), 64'h1);
    check("t5_data", bus.encrypters_data, 64'h0F1E2D3C4B5A6978);
    tick();
    check("t5_idx", 64'(dispatch_idx), 64'd1);
    check("t5_ferr_sticky", 64'(frame_error), 64'd1);

    // 6. Asynchronous reset while a load is pending
    apply_reset();
    bus.encrypters_ready = 4'b1011;
    send_nibble(4'h3, 1'b0);
    send_pkt(64'h1111111111111111, 16'h0000);
    send_pkt(64'h2222222222222222, 16'h0000);
    send_pkt(64'h3333333333333333, 16'h0000);
    tick();
    tick();
    check("t6_load_held", 64'(bus.encrypters_load), 64'h4);
    check("t6_idx_held", 64'(dispatch_idx), 64'd2);
    check("t6_ferr_set", 64'(frame_error), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_load", 64'(bus.encrypters_load), 64'h0);
    check("t6_rst_idx", 64'(dispatch_idx), 64'd0);
    check("t6_rst_ready", 64'(bus.qspi_ready), 64'd1);
    check("t6_rst_ferr", 64'(frame_error), 64'd0);
    check("t6_rst_data", bus.encrypters_data, 64'd0);
    tick();
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
